muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide execution unit sitting directly downstream of `Register_File` read ports and upstream of its write port. It accepts two source operands plus a destination register index, computes over DATA_WIDTH cycles (one bit per cycle), and then issues a single-cycle write-back using the register file's `write_en`/`write_reg`/`write_data` convention. The core pipeline stalls on `busy`.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply / divide unit that sits between the register
// file read ports and its write port. It produces one result bit per cycle
// over DATA_WIDTH cycles, then issues a single-cycle write-back.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   start       request, sampled only while idle
//   op          00 MULU, 01 MULHU, 10 DIVU, 11 REMU
//   rs_data1    operand A / dividend
//   rs_data2    operand B / divisor
//   rd_addr     destination register index
//   busy        high from the cycle after acceptance through write-back
//   done        one-cycle pulse in write-back
//   write_en    register file write strobe (suppressed for rd = 0)
//   write_reg   write-back index (holds its value outside write-back)
//   write_data  write-back value (holds its value outside write-back)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] rs_data1,
   input  logic [DATA_WIDTH-1:0] rs_data2,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0] write_data
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] OP_MULU  = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [1:0]            r_op;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [W-1:0]          r_opa;    // multiplicand, or divisor for divide ops
   logic [2*W-1:0]        r_prod;   // {accumulator, remaining multiplier bits}
   logic [W-1:0]          r_quo;    // dividend shifting out, quotient shifting in
   logic [W-1:0]          r_rem;    // partial remainder (always < divisor)
   logic                  r_busy;
   logic                  r_done;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_wreg;
   logic [W-1:0]          r_wdata;

   // Multiply step: conditionally add the multiplicand to the upper half, then
   // shift the whole product right; the carry of the add becomes the new MSB.
   logic [W-1:0]   w_addend;
   logic [W:0]     w_sum;
   logic [2*W-1:0] w_prod_next;

   assign w_addend    = r_prod[0] ? r_opa : '0;
   assign w_sum       = {1'b0, r_prod[2*W-1:W]} + {1'b0, w_addend};
   assign w_prod_next = {w_sum, r_prod[W-1:1]};

   // Restoring divide step on a W+1-bit partial remainder. A set MSB in the
   // trial difference means the subtraction went negative, so the shifted
   // value is kept (restored) and the quotient bit is 0.
   logic [W:0]   w_rem_shift;
   logic [W:0]   w_rem_sub;
   logic         w_ge;
   logic [W-1:0] w_rem_next;
   logic [W-1:0] w_quo_next;

   assign w_rem_shift = {r_rem, r_quo[W-1]};
   assign w_rem_sub   = w_rem_shift - {1'b0, r_opa};
   assign w_ge        = ~w_rem_sub[W];
   assign w_rem_next  = w_ge ? w_rem_sub[W-1:0] : w_rem_shift[W-1:0];
   assign w_quo_next  = {r_quo[W-2:0], w_ge};

   // Final result, taken from the next-state values of the last iteration so
   // write-back is registered on the same edge that finishes the iteration.
   logic [W-1:0] w_result;
   always_comb begin
      w_result = '0;
      case (r_op)
         OP_MULU:  w_result = w_prod_next[W-1:0];
         OP_MULHU: w_result = w_prod_next[2*W-1:W];
         OP_DIVU:  w_result = w_quo_next;
         OP_REMU:  w_result = w_rem_next;
         default:  w_result = '0;
      endcase
   end

   // Divide by zero skips the iterations: quotient all ones, remainder = dividend.
   logic         w_div0;
   logic [W-1:0] w_div0_val;

   assign w_div0     = op[1] && (rs_data2 == '0);
   assign w_div0_val = op[0] ? rs_data1 : '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_rd    <= '0;
         r_opa   <= '0;
         r_prod  <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wen   <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_rd   <= rd_addr;
                  r_opa  <= op[1] ? rs_data2 : rs_data1;
                  r_prod <= {{W{1'b0}}, rs_data2};
                  r_quo  <= rs_data1;
                  r_rem  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (w_div0) begin
                     r_state <= S_WB;
                     r_done  <= 1'b1;
                     r_wen   <= (rd_addr != '0);
                     r_wreg  <= rd_addr;
                     r_wdata <= w_div0_val;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (r_op[1]) begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
               end else begin
                  r_prod <= w_prod_next;
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(W - 1)) begin
                  r_state <= S_WB;
                  r_done  <= 1'b1;
                  r_wen   <= (r_rd != '0);
                  r_wreg  <= r_rd;
                  r_wdata <= w_result;
               end
            end
            S_WB: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_wen   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_wen   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign write_en   = r_wen;
   assign write_reg  = r_wreg;
   assign write_data = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [DW-1:0] rs_data1;
   logic [DW-1:0] rs_data2;
   logic [AW-1:0] rd_addr;
   logic          busy;
   logic          done;
   logic          write_en;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;

   muldiv_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_data1  (rs_data1),
      .rs_data2  (rs_data2),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .done      (done),
      .write_en  (write_en),
      .write_reg (write_reg),
      .write_data(write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition.
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Observations from the last operation.
   logic [31:0] g_data;
   logic [4:0]  g_reg;
   int          g_lat, g_busy_cnt, g_done_cnt, g_wen_cnt;

   // Issue one operation and watch it through write-back. Optionally scramble
   // the inputs after acceptance and pulse start mid-run and during WB.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit scramble, input bit inject);
      g_data = '0; g_reg = '0; g_lat = 0; g_busy_cnt = 0; g_done_cnt = 0; g_wen_cnt = 0;
      @(negedge clk);
      start = 1'b1; op = o; rs_data1 = a; rs_data2 = b; rd_addr = rd;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scramble) begin
         rs_data1 = $urandom; rs_data2 = $urandom;
         op = 2'($urandom_range(0, 3)); rd_addr = 5'($urandom_range(0, 31));
      end
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) g_busy_cnt++;
         if (write_en) g_wen_cnt++;
         if (done) begin
            g_done_cnt++;
            if (g_done_cnt == 1) begin
               g_lat = cyc; g_data = write_data; g_reg = write_reg;
            end
            if (inject) start = 1'b1;   // start in WB must be ignored
         end
         if (inject && cyc == 10) begin
            start = 1'b1; op = 2'b00; rs_data1 = 32'd1000; rs_data2 = 32'd3; rd_addr = 5'd9;
         end
         if (!busy && g_done_cnt > 0) break;
      end
      start = 1'b0;
   endtask

   task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                           input bit scramble, input bit inject);
      int exp_lat;
      exp_lat = (o[1] && b == 0) ? 1 : 33;
      do_op(o, a, b, rd, scramble, inject);
      chk({tag, ".data"}, 64'(g_data), 64'(exp));
      chk({tag, ".reg"}, 64'(g_reg), 64'(rd));
      chk({tag, ".done_cnt"}, 64'(g_done_cnt), 64'd1);
      chk({tag, ".wen_cnt"}, 64'(g_wen_cnt), (rd != 0) ? 64'd1 : 64'd0);
      chk({tag, ".latency"}, 64'(g_lat), 64'(exp_lat));
      chk({tag, ".busy_cycles"}, 64'(g_busy_cnt), 64'(exp_lat));
      $display("op=%0d a=%h b=%h rd=%0d -> data=%h reg=%0d lat=%0d busy=%0d wen=%0d",
               o, a, b, rd, g_data, g_reg, g_lat, g_busy_cnt, g_wen_cnt);
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wen_seen;
      reset = 1'b1; start = 1'b0; op = '0; rs_data1 = '0; rs_data2 = '0; rd_addr = '0;

      vecs.push_back('{"mulu_7x6",      2'b00, 32'd7,          32'd6,          5'd5,  32'h0000_002A});
      vecs.push_back('{"mulu_ffx2",     2'b00, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFE});
      vecs.push_back('{"mulhu_ffx2",    2'b01, 32'hFFFF_FFFF,  32'd2,          5'd4,  32'h0000_0001});
      vecs.push_back('{"mulhu_ffxff",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFE});
      vecs.push_back('{"divu_100_7",    2'b10, 32'd100,        32'd7,          5'd7,  32'h0000_000E});
      vecs.push_back('{"remu_100_7",    2'b11, 32'd100,        32'd7,          5'd8,  32'h0000_0002});
      vecs.push_back('{"divu_by0",      2'b10, 32'h1234_5678,  32'd0,          5'd10, 32'hFFFF_FFFF});
      vecs.push_back('{"remu_by0",      2'b11, 32'h1234_5678,  32'd0,          5'd11, 32'h1234_5678});
      vecs.push_back('{"mulu_rd0",      2'b00, 32'd3,          32'd3,          5'd0,  32'h0000_0009});
      vecs.push_back('{"divu_max_1",    2'b10, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF});
      vecs.push_back('{"remu_small",    2'b11, 32'd5,          32'hFFFF_FFFF,  5'd12, 32'h0000_0005});

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.wen", 64'(write_en), 64'd0);
      chk("reset.wreg", 64'(write_reg), 64'd0);
      chk("reset.wdata", 64'(write_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table.
      foreach (vecs[i])
         check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1, 1'b0);

      // Outputs hold their last values outside write-back.
      @(negedge clk);
      chk("hold.wdata", 64'(write_data), 64'h5);
      chk("hold.wreg", 64'(write_reg), 64'd12);

      // start pulsed mid-run and in WB: ignored, original result written.
      check_op("ignore_start", 2'b10, 32'd1000, 32'd10, 5'd13, 32'd100, 1'b0, 1'b1);

      // Randomized against the reference model.
      for (int n = 0; n < 24; n++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         logic [4:0]  rr;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
         if (n % 5 == 0) rb = rb >> $urandom_range(0, 31);
         rr = 5'($urandom_range(0, 31));
         check_op($sformatf("rand%0d", n), ro, ra, rb, rr, model(ro, ra, rb), 1'b1, 1'b0);
      end

      // Reset around iteration 10 of a divide: abandoned, never written.
      @(negedge clk);
      start = 1'b1; op = 2'b10; rs_data1 = 32'd123456; rs_data2 = 32'd77; rd_addr = 5'd14;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset.busy", 64'(busy), 64'd0);
      chk("midreset.wen", 64'(write_en), 64'd0);
      chk("midreset.done", 64'(done), 64'd0);
      wen_seen = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (cyc == 2) reset = 1'b0;
         if (write_en || done || busy) wen_seen++;
      end
      chk("midreset.no_activity", 64'(wen_seen), 64'd0);
      $display("reset mid-divide: busy=%0d wen=%0d activity=%0d", busy, write_en, wen_seen);

      check_op("after_reset", 2'b00, 32'd5, 32'd5, 5'd1, 32'h0000_0019, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
